div_recon_16bit: RTL and testbench



---
 rtl/div_recon_16bit.sv | 93 +++++++++
 tb/tb_div_recon_16bit.sv | 149 ++++++++++++++
 2 files changed

// File: rtl/div_recon_16bit.sv
// Rebuilds q*b + r (16x8+16 unsigned) with a shift-add datapath, one multiplier bit per cycle.
// Latency: 8 cycles busy, done pulses the cycle after the 8th iteration; start is ignored while busy.
module div_recon_16bit (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] q,
    input  logic [7:0]  b,
    input  logic [15:0] r,
    output logic        busy,
    output logic        done,
    output logic [23:0] product,
    output logic        fits16
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state;
    logic [23:0] acc;
    logic [23:0] mcand;
    logic [7:0]  mplier;
    logic [3:0]  cnt;
    logic [23:0] acc_nxt;

    // Max result is 24'hFFFF00, so the 24-bit add needs no carry-out.
    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) begin
            acc_nxt = acc + mcand;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            acc     <= 24'h0;
            mcand   <= 24'h0;
            mplier  <= 8'h0;
            cnt     <= 4'h0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= 24'h0;
            fits16  <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        acc    <= {8'h0, r};
                        mcand  <= {8'h0, q};
                        mplier <= b;
                        cnt    <= 4'd8;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        product <= acc_nxt;
                        fits16  <= (acc_nxt[23:16] == 8'h0);
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    done <= 1'b0;
                    // A start during the done cycle chains straight into the next operation.
                    if (start) begin
                        acc    <= {8'h0, r};
                        mcand  <= {8'h0, q};
                        mplier <= b;
                        cnt    <= 4'd8;
                        busy   <= 1'b1;
                        state  <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_div_recon_16bit.sv
// Randomized self-checking bench for div_recon_16bit against an arithmetic q*b+r model.
module tb_div_recon_16bit;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] q;
    logic [7:0]  b;
    logic [15:0] r;
    logic        busy;
    logic        done;
    logic [23:0] product;
    logic        fits16;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_recon_16bit dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .q       (q),
        .b       (b),
        .r       (r),
        .busy    (busy),
        .done    (done),
        .product (product),
        .fits16  (fits16)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        if (obs !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called at a negedge; drives start now and returns at the negedge where done is seen.
    task automatic run_op(input string tag, input logic [15:0] qi, input logic [7:0] bi,
                          input logic [15:0] ri, input int glitch);
        longint exp;
        int     n;
        int     busy_cnt;
        bit     seen;
        exp = longint'(qi) * longint'(bi) + longint'(ri);
        start = 1'b1; q = qi; b = bi; r = ri;
        n = 0; busy_cnt = 0; seen = 1'b0;
        while (!seen && n < 20) begin
            @(negedge clk);
            n++;
            if (n == 1) begin
                start = 1'b0; q = 16'($urandom); b = 8'($urandom); r = 16'($urandom);
            end
            if (glitch > 0 && n == glitch) begin
                start = 1'b1; q = 16'($urandom); b = 8'($urandom); r = 16'($urandom);
            end
            if (glitch > 0 && n == glitch + 1) start = 1'b0;
            if (done) seen = 1'b1;
            else if (busy) busy_cnt++;
        end
        start = 1'b0;
        check({tag, " done"}, 32'(seen), 32'd1);
        check({tag, " latency"}, 32'(n), 32'd9);
        check({tag, " busy_cycles"}, 32'(busy_cnt), 32'd8);
        check({tag, " product"}, 32'(product), 32'(exp));
        check({tag, " fits16"}, 32'(fits16), 32'(exp <= 64'hFFFF));
    endtask

    task automatic expect_idle(input string tag);
        @(negedge clk);
        check({tag, " done_one_cycle"}, 32'(done), 32'd0);
        check({tag, " busy_after"}, 32'(busy), 32'd0);
    endtask

    initial begin
        int dcnt;
        logic [15:0] a;
        logic [7:0]  bb;
        rst = 1'b1; start = 1'b0; q = 16'h0; b = 8'h0; r = 16'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst product", 32'(product), 32'h0);
        check("rst fits16", 32'(fits16), 32'd1);
        check("rst busy", 32'(busy), 32'd0);
        check("rst done", 32'(done), 32'd0);
        dcnt = 0;
        repeat (20) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("idle no_activity", 32'(dcnt), 32'd0);

        run_op("basic", 16'd1000, 8'd65, 16'd35, 0);
        check("basic value", 32'(product), 32'h00FE0B);
        expect_idle("basic");
        run_op("max", 16'hFFFF, 8'hFF, 16'hFFFF, 0);
        check("max value", 32'(product), 32'hFFFF00);
        check("max fits16", 32'(fits16), 32'd0);
        expect_idle("max");
        run_op("b0", 16'hFFFF, 8'h00, 16'h1234, 0);
        check("b0 value", 32'(product), 32'h001234);
        expect_idle("b0");
        run_op("glitch", 16'd777, 8'd200, 16'd9, 4);
        expect_idle("glitch");

        // Back-to-back: second start is driven during the done cycle.
        run_op("b2b_first", 16'd1000, 8'd65, 16'd35, 0);
        run_op("b2b_second", 16'd1234, 8'd56, 16'd7, 0);
        check("b2b value", 32'(product), 32'd69111);
        expect_idle("b2b");

        // Reset in the middle of an operation.
        start = 1'b1; q = 16'hABCD; b = 8'h77; r = 16'h1111;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        check("midrst product", 32'(product), 32'h0);
        check("midrst fits16", 32'(fits16), 32'd1);
        check("midrst busy", 32'(busy), 32'd0);
        check("midrst done", 32'(done), 32'd0);
        dcnt = 0;
        repeat (12) begin
            @(negedge clk);
            if (done || busy) dcnt++;
        end
        check("midrst no_done", 32'(dcnt), 32'd0);
        run_op("after_rst", 16'd4321, 8'd3, 16'd2, 0);
        expect_idle("after_rst");

        // Round trip through an ideal 16/8 divider.
        for (int i = 0; i < 1000; i++) begin
            a  = 16'($urandom);
            bb = 8'($urandom_range(255, 1));
            run_op("rt", 16'(a / 16'(bb)), bb, 16'(a % 16'(bb)), 0);
            check("rt dividend", 32'(product), 32'(a));
            check("rt fits16", 32'(fits16), 32'd1);
            if (i % 2 == 0) @(negedge clk);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
